// File: rtl/pwm_ramp_multi.sv
// Multi-channel PWM with per-channel slew-limited duty ramping toward a written target.
// Optional define PWM_PHASE_STAGGER_EN spreads each channel's compare phase evenly over the period.
module pwm_ramp_multi #(
    parameter int CHANNELS  = 4,
    parameter int DUTY_W    = 8,
    parameter int PRESCALE  = 16,
    parameter int RAMP_STEP = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                wr_en,
    input  logic [2:0]          wr_ch,
    input  logic [DUTY_W-1:0]   wr_duty,
    output logic [CHANNELS-1:0] pwm,
    output logic [CHANNELS-1:0] busy,
    output logic                period_start
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]   PS_LAST    = PS_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] PHASE_LAST = '1;
    // RAMP_STEP is expected to be at most 2^DUTY_W; the widened step keeps that full range.
    localparam logic [DUTY_W:0]   STEP_EXT   = (DUTY_W + 1)'(RAMP_STEP);
    localparam logic [DUTY_W-1:0] STEP_N     = DUTY_W'(RAMP_STEP);

    logic [PS_W-1:0]   presc_reg;
    logic [DUTY_W-1:0] phase_reg;
    logic              period_start_reg;
    logic              tick;
    logic              boundary;

    assign tick         = en && (presc_reg == PS_LAST);
    assign boundary     = tick && (phase_reg == PHASE_LAST);
    assign period_start = period_start_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg        <= '0;
            phase_reg        <= '0;
            period_start_reg <= 1'b0;
        end else begin
            if (en) begin
                presc_reg <= tick ? '0 : presc_reg + 1'b1;
            end
            if (tick) begin
                phase_reg <= phase_reg + 1'b1;
            end
            period_start_reg <= boundary;
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            localparam logic [2:0] CH_IDX = 3'(gi);
`ifdef PWM_PHASE_STAGGER_EN
            localparam int OFFSET_INT = (gi * ((1 << DUTY_W) / CHANNELS)) % (1 << DUTY_W);
`else
            localparam int OFFSET_INT = 0;
`endif
            localparam logic [DUTY_W-1:0] OFFSET = DUTY_W'(OFFSET_INT);

            logic [DUTY_W-1:0] target_reg;
            logic [DUTY_W-1:0] cur_reg;
            logic [DUTY_W-1:0] cur_next;
            logic [DUTY_W-1:0] cmp_phase;
            logic [DUTY_W:0]   cur_ext;
            logic [DUTY_W:0]   tgt_ext;
            logic [DUTY_W:0]   up_sum;
            logic              pwm_bit_reg;
            logic              busy_bit_reg;

            // Modulo wrap of the staggered phase comes for free from the DUTY_W-bit sum.
            assign cmp_phase = phase_reg + OFFSET;

            always_comb begin
                cur_ext  = {1'b0, cur_reg};
                tgt_ext  = {1'b0, target_reg};
                up_sum   = cur_ext + STEP_EXT;
                cur_next = cur_reg;
                if (RAMP_STEP == 0) begin
                    cur_next = target_reg;
                end else if (cur_ext < tgt_ext) begin
                    cur_next = (up_sum > tgt_ext) ? target_reg : up_sum[DUTY_W-1:0];
                end else if (cur_ext > tgt_ext) begin
                    cur_next = ((tgt_ext + STEP_EXT) > cur_ext) ? target_reg : (cur_reg - STEP_N);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    target_reg   <= '0;
                    cur_reg      <= '0;
                    pwm_bit_reg  <= 1'b0;
                    busy_bit_reg <= 1'b0;
                end else begin
                    if (wr_en && (wr_ch == CH_IDX)) begin
                        target_reg <= wr_duty;
                    end
                    // cur only moves with phase wrapping to 0, so a period never sees two duties.
                    if (boundary) begin
                        cur_reg <= cur_next;
                    end
                    pwm_bit_reg  <= en && (cur_reg > cmp_phase);
                    busy_bit_reg <= (cur_reg != target_reg);
                end
            end

            assign pwm[gi]  = pwm_bit_reg;
            assign busy[gi] = busy_bit_reg;
        end
    endgenerate

endmodule

// File: tb/tb_pwm_ramp_multi.sv
// Scoreboard bench for pwm_ramp_multi: a period-level reference model predicts each cycle's outputs.
module tb_pwm_ramp_multi;

    localparam int CH    = 4;
    localparam int DW    = 4;
    localparam int PS    = 2;
    localparam int RS    = 4;
    localparam int STEPS = 1 << DW;
    localparam int PER   = PS * STEPS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_ch = '0;
    logic [DW-1:0] wr_duty = '0;
    logic [CH-1:0] pwm;
    logic [CH-1:0] busy;
    logic          period_start;

    pwm_ramp_multi #(
        .CHANNELS (CH),
        .DUTY_W   (DW),
        .PRESCALE (PS),
        .RAMP_STEP(RS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_duty     (wr_duty),
        .pwm         (pwm),
        .busy        (busy),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] pwm;
        logic [CH-1:0] busy;
        logic          ps;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: enabled clocks into the current period, plus per-channel duties.
    int m_clks = 0;
    int m_tgt[CH];
    int m_cur[CH];

    function automatic int stagger_off(input int i);
`ifdef PWM_PHASE_STAGGER_EN
        return i * (STEPS / CH);
`else
        return 0 * i;
`endif
    endfunction

    function automatic int ramp(input int cur, input int tgt);
        if (RS == 0) return tgt;
        if (cur < tgt) return (cur + RS < tgt) ? cur + RS : tgt;
        if (cur > tgt) return (cur - RS > tgt) ? cur - RS : tgt;
        return cur;
    endfunction

    task automatic drive(input logic r, input logic e, input logic we,
                         input logic [2:0] ch, input logic [DW-1:0] d);
        exp_t x;
        int   phase;
        bit   bnd;
        @(negedge clk);
        reset = r; en = e; wr_en = we; wr_ch = ch; wr_duty = d;
        x = '0;
        if (r) begin
            m_clks = 0;
            for (int i = 0; i < CH; i++) begin
                m_tgt[i] = 0;
                m_cur[i] = 0;
            end
        end else begin
            phase = m_clks / PS;
            bnd   = e && (m_clks == PER - 1);
            for (int i = 0; i < CH; i++) begin
                x.pwm[i]  = e && (m_cur[i] > ((phase + stagger_off(i)) % STEPS));
                x.busy[i] = (m_cur[i] != m_tgt[i]);
            end
            x.ps = bnd;
            if (bnd) begin
                for (int i = 0; i < CH; i++) m_cur[i] = ramp(m_cur[i], m_tgt[i]);
            end
            if (we && int'(ch) < CH) m_tgt[ch] = int'(d);
            if (e) m_clks = (m_clks + 1) % PER;
            if (we) $display("WR t=%0t ch=%0d duty=%0d", $time, ch, d);
        end
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n, input logic e);
        for (int k = 0; k < n; k++) drive(1'b0, e, 1'b0, 3'd0, '0);
    endtask

    // Monitor: outputs settle just after each edge; compare against the oldest prediction.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checks++;
                if (pwm !== x.pwm || busy !== x.busy || period_start !== x.ps) begin
                    errors++;
                    $display("FAIL outputs t=%0t pwm=%b exp %b busy=%b exp %b period_start=%b exp %b",
                             $time, pwm, x.pwm, busy, x.busy, period_start, x.ps);
                end
            end
        end
    end

    initial begin
        logic e_state;
        for (int i = 0; i < CH; i++) begin
            m_tgt[i] = 0;
            m_cur[i] = 0;
        end
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0, 3'd0, '0);
        idle(3 * PER, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 3'd0, 4'd8);
        idle(4 * PER, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 3'd0, 4'd1);
        idle(3 * PER, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 3'd1, 4'd15);
        idle(3 * PER, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 3'd1, 4'd0);
        idle(2 * PER, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 3'd5, 4'd9);
        idle(PER, 1'b1);
        // Land a write on the boundary cycle itself.
        while (m_clks != PER - 1) idle(1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 3'd2, 4'd12);
        idle(2 * PER + 10, 1'b1);
        idle(10, 1'b0);
        idle(2 * PER, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 3'd3, 4'd15);
        idle(PER + 17, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 3'd0, '0);
        idle(PER, 1'b1);

        e_state = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 59) == 0) e_state = ~e_state;
            if ($urandom_range(0, 699) == 0) begin
                drive(1'b1, e_state, 1'b0, 3'd0, '0);
            end else if ($urandom_range(0, 29) == 0) begin
                drive(1'b0, e_state, 1'b1, 3'($urandom_range(0, 7)), DW'($urandom_range(0, STEPS - 1)));
            end else begin
                drive(1'b0, e_state, 1'b0, 3'($urandom_range(0, 7)), DW'($urandom_range(0, STEPS - 1)));
            end
        end
        idle(2, 1'b1);
        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
